// File: rtl/i2c_master_arbiter.sv
`timescale 1ns/1ps
// i2c_master_arbiter
// Shares one i2c_master between NUM_REQ requesters. Requesters are served in
// round-robin order. The winner's address, data and direction are latched and
// a single transfer is launched. The master's busy/idle handshake is guarded
// by two watchdogs. Completion (done) or timeout (err) is pulsed back to the
// requester that owns the grant.
//
// Ports
//   clk_in, rst_in   system clock, asynchronous active-high reset
//   req              per-requester request level (held until done/err)
//   req_addr         packed 7-bit addresses, requester i at [7i+6:7i]
//   req_data         packed write bytes, requester i at [8i+7:8i]
//   req_rw           per-requester direction (1 = read)
//   grant            one-hot owner of the master, zero when idle
//   done / err       one-cycle completion / timeout pulse to the owner
//   rd_data          last captured read byte
//   m_start          one-cycle launch pulse to the master
//   m_addr/m_data/m_rw  latched transfer parameters to the master
//   m_ready          master idle indicator (0 = transfer in progress)
//   m_rdata          master read byte, valid when m_ready rises after a read
module i2c_master_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int START_TO = 16,
    parameter int XFER_TO  = 1024,
    parameter int CNT_W    = 11
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_rw,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [7:0]             rd_data,
    output logic                   m_start,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data,
    output logic                   m_rw,
    input  logic                   m_ready,
    input  logic [7:0]             m_rdata
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] XFER_LIM  = CNT_W'(XFER_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [PTR_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]     r_wdog;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_err;
    logic [7:0]           r_rd_data;
    logic                 r_m_start;
    logic [6:0]           r_m_addr;
    logic [7:0]           r_m_data;
    logic                 r_m_rw;

    logic                 w_go;
    logic                 w_found;
    logic [PTR_W-1:0]     w_win_idx;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [6:0]           w_win_addr;
    logic [7:0]           w_win_data;
    logic                 w_win_rw;
    logic                 w_start_to;
    logic                 w_xfer_to;

    logic [6:0]           w_addr_arr [NUM_REQ];
    logic [7:0]           w_data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = req_addr[g*7 +: 7];
        assign w_data_arr[g] = req_data[g*8 +: 8];
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_win_oh   = '0;
        w_win_addr = '0;
        w_win_data = '0;
        w_win_rw   = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            int unsigned idx;
            logic [PTR_W-1:0] sel;
            idx = ({{(32-PTR_W){1'b0}}, r_rr_ptr} + i) % unsigned'(NUM_REQ);
            sel = PTR_W'(idx);
            if (!w_found && req[sel]) begin
                w_found       = 1'b1;
                w_win_idx     = sel;
                w_win_oh[sel] = 1'b1;
                w_win_addr    = w_addr_arr[sel];
                w_win_data    = w_data_arr[sel];
                w_win_rw      = req_rw[sel];
            end
        end
    end

    assign w_go       = m_ready && w_found;
    assign w_start_to = (r_state == S_WAIT_BUSY) && m_ready  && (r_wdog == START_LIM);
    assign w_xfer_to  = (r_state == S_WAIT_DONE) && !m_ready && (r_wdog == XFER_LIM);

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_go) w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!m_ready)        w_next = S_WAIT_DONE;
                else if (w_start_to) w_next = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (m_ready)         w_next = S_FINISH;
                else if (w_xfer_to)  w_next = S_IDLE;
            end
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Datapath registers. m_start is registered from ISSUE so that grant
    // leads the launch pulse by one cycle; the watchdog therefore starts
    // counting from zero in the same cycle m_start is seen by the master.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rr_ptr  <= PTR_W'(NUM_REQ - 1);
            r_wdog    <= '0;
            r_grant   <= '0;
            r_err     <= '0;
            r_rd_data <= '0;
            r_m_start <= 1'b0;
            r_m_addr  <= '0;
            r_m_data  <= '0;
            r_m_rw    <= 1'b0;
        end else begin
            r_err     <= '0;
            r_m_start <= (r_state == S_ISSUE);
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_grant  <= w_win_oh;
                        r_m_addr <= w_win_addr;
                        r_m_data <= w_win_data;
                        r_m_rw   <= w_win_rw;
                        r_rr_ptr <= w_win_idx;
                    end
                end
                S_ISSUE: begin
                    r_wdog <= '0;
                end
                S_WAIT_BUSY: begin
                    if (!m_ready) begin
                        r_wdog <= '0;
                    end else if (w_start_to) begin
                        r_err   <= r_grant;
                        r_grant <= '0;
                    end else begin
                        r_wdog <= r_wdog + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (m_ready) begin
                        if (r_m_rw) r_rd_data <= m_rdata;
                    end else if (w_xfer_to) begin
                        r_err   <= r_grant;
                        r_grant <= '0;
                    end else begin
                        r_wdog <= r_wdog + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    r_grant <= '0;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Outputs; done is decoded from FINISH while grant still names the owner.
    always_comb begin
        done    = (r_state == S_FINISH) ? r_grant : '0;
        grant   = r_grant;
        err     = r_err;
        rd_data = r_rd_data;
        m_start = r_m_start;
        m_addr  = r_m_addr;
        m_data  = r_m_data;
        m_rw    = r_m_rw;
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
`timescale 1ns/1ps
// Directed self-checking bench for i2c_master_arbiter with a hand-driven
// master model on m_ready/m_rdata.
module tb_i2c_master_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int START_TO = 16;
    localparam int XFER_TO  = 1024;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_rw;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic [7:0]           rd_data;
    logic                 m_start;
    logic [6:0]           m_addr;
    logic [7:0]           m_data;
    logic                 m_rw;
    logic                 m_ready;
    logic [7:0]           m_rdata;

    int checks   = 0;
    int failures = 0;

    i2c_master_arbiter #(
        .NUM_REQ (NUM_REQ),
        .START_TO(START_TO),
        .XFER_TO (XFER_TO),
        .CNT_W   (11)
    ) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .req     (req),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_rw  (req_rw),
        .grant   (grant),
        .done    (done),
        .err     (err),
        .rd_data (rd_data),
        .m_start (m_start),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .m_rw    (m_rw),
        .m_ready (m_ready),
        .m_rdata (m_rdata)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
        req_addr[i*7 +: 7] = a;
        req_data[i*8 +: 8] = d;
        req_rw[i]          = rw;
    endtask

    // One complete transfer, starting in an IDLE cycle with req already set.
    task automatic xfer(input string tag, input logic [3:0] exp_gnt, input logic [6:0] exp_addr,
                        input logic [7:0] exp_data, input logic exp_rw, input int busy,
                        input logic [7:0] rdata, input logic [7:0] exp_rd);
        int n;
        n = 0;
        while (grant == '0 && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_grant"}, grant, exp_gnt);
        check_eq({tag, "_start_lag"}, m_start, 1'b0);
        step();
        check_eq({tag, "_start"}, m_start, 1'b1);
        check_eq({tag, "_addr"}, m_addr, exp_addr);
        check_eq({tag, "_data"}, m_data, exp_data);
        check_eq({tag, "_rw"}, m_rw, exp_rw);
        step();
        check_eq({tag, "_start_pulse"}, m_start, 1'b0);
        m_ready = 1'b0;
        m_rdata = rdata;
        repeat (busy) step();
        m_ready = 1'b1;
        step();
        check_eq({tag, "_done"}, done, exp_gnt);
        check_eq({tag, "_err"}, err, 4'b0000);
        check_eq({tag, "_rd"}, rd_data, exp_rd);
        step();
        check_eq({tag, "_done_end"}, done, 4'b0000);
        check_eq({tag, "_grant_end"}, grant, 4'b0000);
    endtask

    initial begin
        #300us;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int n;
        logic [3:0] seen;
        logic       saw_done;

        rst_in   = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        req_rw   = '0;
        m_ready  = 1'b1;
        m_rdata  = '0;
        repeat (3) step();
        rst_in = 1'b0;

        // Reset state
        check_eq("rst_grant", grant, 4'b0000);
        check_eq("rst_done", done, 4'b0000);
        check_eq("rst_err", err, 4'b0000);
        check_eq("rst_rd", rd_data, 8'h00);
        check_eq("rst_start", m_start, 1'b0);
        check_eq("rst_addr", m_addr, 7'h00);
        check_eq("rst_data", m_data, 8'h00);
        check_eq("rst_rw", m_rw, 1'b0);
        step();

        // Single write; a write must not capture m_rdata
        set_req(0, 7'h50, 8'hA5, 1'b0);
        req = 4'b0001;
        xfer("t1", 4'b0001, 7'h50, 8'hA5, 1'b0, 20, 8'hEE, 8'h00);
        req = '0;
        step();

        // Read capture from requester 2, then held
        set_req(2, 7'h3C, 8'h11, 1'b1);
        req = 4'b0100;
        xfer("t2", 4'b0100, 7'h3C, 8'h11, 1'b1, 6, 8'h5E, 8'h5E);
        req = '0;
        repeat (3) step();
        check_eq("t2_rd_hold", rd_data, 8'h5E);

        // Round robin with all requesters held from reset
        rst_in = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 7'(7'h10 + i), 8'(8'hC0 + i), (i == 1));
        end
        req = 4'b1111;
        step();
        check_eq("t3_rst_rd", rd_data, 8'h00);
        rst_in = 1'b0;
        for (int t = 0; t < 5; t++) begin
            int idx;
            idx = t % NUM_REQ;
            xfer($sformatf("t3_%0d", t), 4'(4'b0001 << idx), 7'(7'h10 + idx), 8'(8'hC0 + idx),
                 (idx == 1), 4, 8'h77, (t == 0) ? 8'h00 : 8'h77);
        end
        req = '0;
        step();

        // Start timeout: master never goes busy
        set_req(2, 7'h22, 8'h33, 1'b0);
        req = 4'b0100;
        n = 0;
        while (grant == '0 && n < 20) begin
            step();
            n++;
        end
        check_eq("t4_grant", grant, 4'b0100);
        step();
        check_eq("t4_start", m_start, 1'b1);
        n = 0;
        saw_done = 1'b0;
        while (err == '0 && n < START_TO + 8) begin
            step();
            n++;
            if (done != '0) saw_done = 1'b1;
        end
        check_eq("t4_latency", n, START_TO);
        check_eq("t4_err", err, 4'b0100);
        check_eq("t4_grant_clr", grant, 4'b0000);
        check_eq("t4_no_done", saw_done, 1'b0);
        req = '0;
        step();
        check_eq("t4_err_pulse", err, 4'b0000);

        // Transfer timeout: master stays busy; requester 3 waits for m_ready
        set_req(0, 7'h05, 8'h06, 1'b0);
        set_req(3, 7'h4F, 8'hF0, 1'b0);
        req = 4'b0001;
        step();
        check_eq("t5_grant", grant, 4'b0001);
        step();
        check_eq("t5_start", m_start, 1'b1);
        step();
        m_ready = 1'b0;
        req = 4'b1001;
        n = 0;
        while (err == '0 && n < XFER_TO + 20) begin
            step();
            n++;
        end
        check_eq("t5_latency", n, XFER_TO + 1);
        check_eq("t5_err", err, 4'b0001);
        check_eq("t5_grant_clr", grant, 4'b0000);
        req = 4'b1000;
        seen = '0;
        repeat (10) begin
            step();
            seen = seen | grant;
        end
        check_eq("t5_hold", seen, 4'b0000);
        m_ready = 1'b1;
        step();
        check_eq("t5_next_grant", grant, 4'b1000);

        // Reset in WAIT_DONE
        step();
        check_eq("t6_start", m_start, 1'b1);
        check_eq("t6_addr", m_addr, 7'h4F);
        step();
        m_ready = 1'b0;
        repeat (3) step();
        #2;
        rst_in = 1'b1;
        #1;
        check_eq("t6_rst_grant", grant, 4'b0000);
        check_eq("t6_rst_done", done, 4'b0000);
        check_eq("t6_rst_err", err, 4'b0000);
        check_eq("t6_rst_addr", m_addr, 7'h00);
        check_eq("t6_rst_data", m_data, 8'h00);
        @(posedge clk_in);
        #1;
        rst_in  = 1'b0;
        m_ready = 1'b1;
        req     = 4'b1001;
        xfer("t6", 4'b0001, 7'h05, 8'h06, 1'b0, 3, 8'h99, 8'h00);
        req = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
